lab3_mem_refill_req_queue: RTL

Memory-side request queue sitting directly downstream of the blocking cache datapath's `memreq_msg` output (refill reads and eviction writes). It buffers 16B memory requests in a small FIFO with val/rdy handshakes on both sides. It also caps the number of in-flight memory transactions by counting requests issued against responses returned. Memory responses pass back to the cache combinationally; the queue only observes them to retire the count.

---
 rtl/lab3_mem_refill_req_queue_pkg.sv | 32 +++
 rtl/lab3_mem_refill_req_fifo.sv | 64 ++++++
 rtl/lab3_mem_refill_req_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/lab3_mem_refill_req_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab3_mem_refill_req_queue_pkg
// Description : Shared 16B memory request/response message formats used by
//               the cache and the memory-side refill request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package lab3_mem_refill_req_queue_pkg;

    localparam logic [2:0] MEM_MSG_READ  = 3'd0;
    localparam logic [2:0] MEM_MSG_WRITE = 3'd1;

    // 3 + 8 + 32 + 4 + 128 = 175 bits
    typedef struct packed {
        logic [2:0]   mtype;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    // 3 + 8 + 2 + 4 + 128 = 145 bits
    typedef struct packed {
        logic [2:0]   mtype;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage
`default_nettype wire

// File: rtl/lab3_mem_refill_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lab3_mem_refill_req_fifo
// Description : Depth-generic request FIFO with registered storage, head/tail
//               pointers and an occupancy counter providing full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module lab3_mem_refill_req_fifo
    import lab3_mem_refill_req_queue_pkg::*;
#(
    parameter int p_num_entries = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq_en,
    input  mem_req_16B_t enq_msg,
    input  logic         deq_en,
    output logic         full,
    output logic         empty,
    output mem_req_16B_t head_msg
);

    localparam int PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int OCC_W = $clog2(p_num_entries) + 1;

    mem_req_16B_t     storage [p_num_entries];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occupancy;

    assign full     = (occupancy == OCC_W'(p_num_entries));
    assign empty    = (occupancy == '0);
    assign head_msg = storage[head];

    // Message storage is data-only and deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enq_en) begin
            storage[tail] <= enq_msg;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (enq_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq_en) begin
                head <= head + PTR_W'(1);
            end
            if (enq_en && !deq_en) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!enq_en && deq_en) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lab3_mem_refill_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : lab3_mem_refill_req_queue
// Description : Memory-side request queue for the blocking cache. Buffers
//               requests, caps in-flight transactions, passes responses
//               straight through and flags responses with nothing pending.
// Revision    : 1.0 - initial release
// ============================================================================
module lab3_mem_refill_req_queue
    import lab3_mem_refill_req_queue_pkg::*;
#(
    parameter int p_num_entries     = 2,
    parameter int p_max_outstanding = 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cache_memreq_val,
    output logic          cache_memreq_rdy,
    input  mem_req_16B_t  cache_memreq_msg,

    output logic          memreq_val,
    input  logic          memreq_rdy,
    output mem_req_16B_t  memreq_msg,

    input  logic          memresp_val,
    output logic          memresp_rdy,
    input  mem_resp_16B_t memresp_msg,

    output logic          cache_memresp_val,
    input  logic          cache_memresp_rdy,
    output mem_resp_16B_t cache_memresp_msg,

    output logic [3:0]    num_outstanding,
    output logic          protocol_err
);

    logic full;
    logic empty;
    logic enq_fire;
    logic issue_fire;
    logic resp_fire;
    logic can_issue;

    // Acceptance depends on queue state only, never on memreq_rdy.
    assign cache_memreq_rdy = !full;
    assign enq_fire         = cache_memreq_val && !full;

    assign can_issue  = (num_outstanding < 4'(p_max_outstanding));
    assign memreq_val = !empty && can_issue;
    assign issue_fire = memreq_val && memreq_rdy;

    // Responses are not buffered; the queue only watches them fire.
    assign cache_memresp_val = memresp_val;
    assign memresp_rdy       = cache_memresp_rdy;
    assign cache_memresp_msg = memresp_msg;
    assign resp_fire         = memresp_val && cache_memresp_rdy;

    lab3_mem_refill_req_fifo #(
        .p_num_entries (p_num_entries)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq_en   (enq_fire),
        .enq_msg  (cache_memreq_msg),
        .deq_en   (issue_fire),
        .full     (full),
        .empty    (empty),
        .head_msg (memreq_msg)
    );

    // In-flight counter: +1 on issue, -1 on response, clamped at zero with a
    // sticky error when a response shows up that nothing was waiting for.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_outstanding <= 4'd0;
            protocol_err    <= 1'b0;
        end else begin
            if (resp_fire && (num_outstanding == 4'd0)) begin
                protocol_err <= 1'b1;
            end
            if (issue_fire && !resp_fire) begin
                num_outstanding <= num_outstanding + 4'd1;
            end else if (!issue_fire && resp_fire && (num_outstanding != 4'd0)) begin
                num_outstanding <= num_outstanding - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire
